// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle MDU stalls and branch flushes.
// Optional perf counters (stall_cnt, flush_cnt) are compiled in with `HAZARD_PERF_EN.
module hazard_unit #(
  parameter int         MDU_CYCLES = 4,
  parameter logic [5:0] OP_LW      = 6'b100011,
  parameter logic [5:0] OP_MDU     = 6'b011100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic [5:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_bubble,
  output logic        mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

  // The detect cycle is one of the stall cycles, so the wait counter starts two short.
  localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] cnt_r;
  logic [3:0] next_cnt_s;
  logic       lu_s;

  assign lu_s = (ex_opcode == OP_LW) && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Control outputs and next-state decode; everything is forced low while rst is high.
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    mdu_busy     = 1'b0;
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    if (rst) begin
      next_state_s = RUN;
      next_cnt_s   = 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ex_opcode == OP_MDU) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            mdu_busy     = 1'b1;
            next_state_s = MDU_WAIT;
            next_cnt_s   = MDU_LOAD;
          end else if (lu_s) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            next_state_s = RUN;
          end
        end
        MDU_WAIT: begin
          // On the cnt==0 cycle ID/EX advances, so the MDU op leaves EX.
          if (cnt_r != 4'd0) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
            mdu_busy   = 1'b1;
            next_cnt_s = cnt_r - 4'd1;
          end else begin
            next_state_s = RUN;
          end
        end
        default: begin
          next_state_s = RUN;
          next_cnt_s   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and MDU wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

`ifdef HAZARD_PERF_EN
  // Perf counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_hold) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (if_id_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (default MDU_CYCLES=4 plus a MDU_CYCLES=2 instance).
module tb_hazard_unit;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_MDU = 6'b011100;
  // Control vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, mdu_busy}
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_MDU  = 6'b110101;
  localparam logic [5:0] C_FL   = 6'b001010;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, br_taken;
  logic [5:0] ex_opcode, ex_opcode2;
  logic       pc_hold1, if_id_hold1, if_id_flush1, id_ex_hold1, id_ex_bubble1, mdu_busy1;
  logic       pc_hold2, if_id_hold2, if_id_flush2, id_ex_hold2, id_ex_bubble2, mdu_busy2;
  logic [5:0] ctl1, ctl2;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt1, flush_cnt1, stall_cnt2, flush_cnt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ctl1 = {pc_hold1, if_id_hold1, if_id_flush1, id_ex_hold1, id_ex_bubble1, mdu_busy1};
  assign ctl2 = {pc_hold2, if_id_hold2, if_id_flush2, id_ex_hold2, id_ex_bubble2, mdu_busy2};

  hazard_unit #(.MDU_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .br_taken(br_taken),
    .pc_hold(pc_hold1), .if_id_hold(if_id_hold1), .if_id_flush(if_id_flush1),
    .id_ex_hold(id_ex_hold1), .id_ex_bubble(id_ex_bubble1), .mdu_busy(mdu_busy1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  hazard_unit #(.MDU_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_opcode(ex_opcode2), .ex_rd(ex_rd), .br_taken(br_taken),
    .pc_hold(pc_hold2), .if_id_hold(if_id_hold2), .if_id_flush(if_id_flush2),
    .id_ex_hold(id_ex_hold2), .id_ex_bubble(id_ex_bubble2), .mdu_busy(mdu_busy2)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic br);
    ex_opcode   = op;
    ex_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs2 = u2;
    br_taken    = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_opcode2 = 6'd0;
    drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 check("reset_idle", ctl1, C_IDLE);
    ex_opcode2 = OP_MDU;
    drive(OP_MDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("reset_gate", ctl1, C_IDLE);
    check("reset_gate2", ctl2, C_IDLE);
    tick();
    check("reset_edge", ctl1, C_IDLE);
    rst = 1'b0;
    ex_opcode2 = 6'd0;
    drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("idle", ctl1, C_IDLE);

    // Load-use and false-hazard cases
    tick(); drive(OP_LW, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); check("lu_rs1", ctl1, C_LU);
    tick(); drive(6'd0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); check("lu_cleared", ctl1, C_IDLE);
    tick(); drive(OP_LW, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); check("lu_rd0", ctl1, C_IDLE);
    tick(); drive(OP_LW, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0); check("lu_rs2_unused", ctl1, C_IDLE);
    drive(OP_LW, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0); check("lu_rs2", ctl1, C_LU);

    // MDU with MDU_CYCLES=4: three stall cycles, branch ignored while waiting
    tick(); drive(OP_MDU, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0); check("mdu_c1", ctl1, C_MDU);
    tick(); drive(OP_MDU, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1); check("mdu_c2_br_ignored", ctl1, C_MDU);
    tick(); drive(OP_MDU, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0); check("mdu_c3", ctl1, C_MDU);
    tick(); drive(OP_MDU, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1); check("mdu_release", ctl1, C_IDLE);
    tick(); drive(OP_LW, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0); check("mdu_then_lu", ctl1, C_LU);

    // MDU with MDU_CYCLES=2: single stall cycle
    tick(); drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex_opcode2 = OP_MDU; #1;
    check("mdu2_c1", ctl2, C_MDU);
    tick(); check("mdu2_release", ctl2, C_IDLE);
    tick(); ex_opcode2 = 6'd0; #1; check("mdu2_idle", ctl2, C_IDLE);

    // Branch priority
    drive(OP_LW, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1); check("br_over_lu", ctl1, C_FL);
    tick(); drive(OP_MDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); check("br_over_mdu", ctl1, C_FL);
    tick(); drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); check("br_stays_run", ctl1, C_IDLE);

    // Reset during the second MDU_WAIT cycle
    tick(); drive(OP_MDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); check("rmid_detect", ctl1, C_MDU);
    tick(); check("rmid_wait1", ctl1, C_MDU);
    tick(); check("rmid_wait2", ctl1, C_MDU);
    rst = 1'b1; #1;
    check("rmid_async", ctl1, C_IDLE);
    tick();
    rst = 1'b0;
    drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("rmid_after", ctl1, C_IDLE);
`ifdef HAZARD_PERF_EN
    check("stall_cnt_reset", stall_cnt1, 32'd0);
    check("flush_cnt_reset", flush_cnt1, 32'd0);
`endif

    // Fresh MDU gives the full stall, then a load-use and two flushes
    tick(); drive(OP_MDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); check("mdu_full_c1", ctl1, C_MDU);
    tick(); check("mdu_full_c2", ctl1, C_MDU);
    tick(); check("mdu_full_c3", ctl1, C_MDU);
    tick(); check("mdu_full_release", ctl1, C_IDLE);
    tick(); drive(OP_LW, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0); check("perf_lu", ctl1, C_LU);
    tick(); drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); check("perf_fl1", ctl1, C_FL);
    tick(); check("perf_fl2", ctl1, C_FL);
    tick(); drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); check("perf_idle", ctl1, C_IDLE);
`ifdef HAZARD_PERF_EN
    check("stall_cnt", stall_cnt1, 32'd4);
    check("flush_cnt", flush_cnt1, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that produces the stall, bubble and flush controls consumed by the IF/ID and ID/EX pipeline registers. It compares the instruction being decoded against the instruction in EX and the EX branch outcome. It sequences three kinds of stall: single-cycle load-use bubbles, multi-cycle stalls for multiply/divide (MDU) instructions, and branch-taken flushes. It sits between the decode stage and the ID/EX register. Its `id_ex_hold` output drives the ID/EX register's hold input.

## Interface
Parameters:
- MDU_CYCLES, 4, total cycles an MDU instruction occupies EX; legal range 2..16
- OP_LW, 6'b100011, load opcode
- OP_MDU, 6'b011100, MDU opcode

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- id_rs1  input  5  source register 1 of the instruction in ID
- id_rs2  input  5  source register 2 of the instruction in ID
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_opcode  input  6  opcode currently held in ID/EX
- ex_rd  input  5  destination register currently held in ID/EX
- br_taken  input  1  branch in EX resolved taken this cycle
- pc_hold  output  1  PC keeps its value
- if_id_hold  output  1  IF/ID keeps its contents
- if_id_flush  output  1  IF/ID loads all-zero (NOP)
- id_ex_hold  output  1  ID/EX keeps its contents
- id_ex_bubble  output  1  ID/EX loads all-zero instead of ID values
- mdu_busy  output  1  MDU stall in progress
- stall_cnt  output  32  stall-cycle counter (HAZARD_PERF_EN only)
- flush_cnt  output  32  flush-event counter (HAZARD_PERF_EN only)

## Operation
- **State.** Two-state FSM {RUN, MDU_WAIT} plus a 4-bit down-counter `cnt`.
- **Reset.** State RUN, cnt 0, perf counters 0.
- **Output gating.** All outputs are combinational from state and inputs. While rst is high, every control output is 0.
- **Load-use detect.** `lu` = (ex_opcode==OP_LW) && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).

In RUN, inputs are evaluated in priority order:
1. **br_taken.**
   - if_id_flush=1 and id_ex_bubble=1.
   - All holds are 0.
   - Stay in RUN.
2. **ex_opcode==OP_MDU.**
   - pc_hold=1, if_id_hold=1, id_ex_hold=1, mdu_busy=1.
   - Load cnt=MDU_CYCLES-2 and go to MDU_WAIT.
3. **lu.**
   - pc_hold=1, if_id_hold=1, id_ex_bubble=1.
   - Stay in RUN.
   - The bubble changes ex_opcode to 0, so the hazard is not re-detected.
4. **Otherwise.** All outputs 0.

In MDU_WAIT:
- **cnt!=0:** pc_hold=1, if_id_hold=1, id_ex_hold=1, mdu_busy=1; decrement cnt.
- **cnt==0:** all outputs 0 and go to RUN. ID/EX advances at this edge, so the MDU instruction leaves EX and is not re-detected.
- br_taken and lu are ignored.

Output invariants:
- id_ex_hold and id_ex_bubble are never both 1.
- if_id_hold and if_id_flush are never both 1.

## Timing
- Load-use costs exactly 1 stall cycle. Outputs assert in the same cycle the hazard is present.
- An MDU instruction stalls upstream for exactly MDU_CYCLES-1 cycles: the detect cycle plus MDU_CYCLES-2 cycles in MDU_WAIT. It then spends one final unstalled cycle in EX, for MDU_CYCLES cycles total in EX.
- With MDU_CYCLES=2 the stall lasts one cycle; MDU_WAIT is entered with cnt=0 and exits immediately.
- Branch flush costs 1 cycle and is combinational with br_taken.
- Back-to-back events work without gaps. Examples:
  - MDU followed by a dependent load: after the MDU instruction leaves, the load enters EX and lu is evaluated normally.
  - A load in EX with br_taken asserted in the same cycle: the flush wins.
- Reset asserted mid-MDU_WAIT: state is forced to RUN and cnt to 0 immediately. Outputs drop to 0 asynchronously.

## Configuration
`HAZARD_PERF_EN` compiles the perf counters in or out.

**Defined:**
- stall_cnt increments on every clock edge where pc_hold is 1.
- flush_cnt increments on every edge where if_id_flush is 1.
- Both counters wrap at 2^32 and reset to 0.

**Undefined:** the stall_cnt and flush_cnt ports and their registers are absent. All other behaviour is identical.

## Test plan
- **Load-use on rs1.** ex_opcode=OP_LW, ex_rd=5, id_rs1=5 -> pc_hold=if_id_hold=id_ex_bubble=1 for 1 cycle. Next cycle with ex_opcode=0 -> all outputs 0.
- **No false hazards.** ex_rd=0 with a load, or id_uses_rs2=0 with id_rs2==ex_rd and id_rs1 different -> no stall.
- **MDU stall, default length.** ex_opcode=OP_MDU with MDU_CYCLES=4 -> id_ex_hold=1 for exactly 3 consecutive cycles, then 0, and the FSM is in RUN. Repeat with MDU_CYCLES=2 -> 1 stall cycle.
- **Branch priority.** br_taken=1 together with an lu condition -> if_id_flush=id_ex_bubble=1, pc_hold=0.
- **Reset mid-stall.** rst pulsed in the 2nd MDU_WAIT cycle -> outputs 0 immediately, state RUN. A new MDU detect afterwards gives the full 3-cycle stall.
- **Perf counters (HAZARD_PERF_EN).** One load-use, one MDU (MDU_CYCLES=4) and two flushes -> stall_cnt=4, flush_cnt=2.
